mdu: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations beside the single-cycle ALU in the EX stage. It takes the same one-hot-op, src1/src2 request style as the ALU, but holds each operation over many cycles. A valid/ready handshake on both the request and result sides lets the pipeline stall EX while the unit is busy. Signed operations are computed on magnitudes through one shared 64-bit shift register, followed by a sign fix-up.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_divstep.sv | 28 ++
 rtl/mdu.sv | 153 +++++++++++++++
 tb/tb_mdu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared op indices, state encoding and RV32M special results.
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam int MDU_MUL    = 0;
    localparam int MDU_MULH   = 1;
    localparam int MDU_MULHSU = 2;
    localparam int MDU_MULHU  = 3;
    localparam int MDU_DIV    = 4;
    localparam int MDU_DIVU   = 5;
    localparam int MDU_REM    = 6;
    localparam int MDU_REMU   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [MDU_WIDTH-1:0] OVF_QUOT  = 32'h8000_0000;

    function automatic logic op_legal(input logic [7:0] op);
        return (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    endfunction

    // Result for divide-by-zero or signed overflow; rem of overflow is 0.
    function automatic logic [MDU_WIDTH-1:0] special_res(input logic                 is_rem,
                                                         input logic                 div0,
                                                         input logic [MDU_WIDTH-1:0] dividend);
        if (div0) begin
            return is_rem ? dividend : DIV0_QUOT;
        end
        return is_rem ? '0 : OVF_QUOT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divstep.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divstep
// Brief    : One restoring-division step on a {rem,quot} register pair.
// Revision : 1.0  initial release
// ============================================================================
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);
    import mdu_pkg::*;

    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_trial;

    // Partial remainder is always < 2*divisor, so bit WIDTH is a clean borrow.
    assign w_part  = {i_rem, i_quot[WIDTH-1]};
    assign w_trial = w_part - {1'b0, i_div};
    assign o_rem   = w_trial[WIDTH] ? w_part[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quot  = {i_quot[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Iterative RV32M multiply/divide unit with valid/ready handshakes.
//            MDU_DIV_FAST_EN: div-by-zero / signed overflow finish in 1 cycle.
// Revision : 1.0  initial release
// ============================================================================
module mdu #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);
    import mdu_pkg::*;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_res;
    logic [7:0]         r_op;
    logic               r_neg;
    logic               r_negr;
    logic               r_div0;
    logic               r_ovf;

    logic               w_legal, w_s1, w_s2, w_in_mul, w_div0, w_ovf;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic               w_is_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_drem, w_dquot;
    logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem, w_special, w_fix;

    assign w_legal  = op_legal(op);
    assign w_s1     = w_legal & (op[MDU_MULH] | op[MDU_MULHSU] | op[MDU_DIV] | op[MDU_REM]) & src1[WIDTH-1];
    assign w_s2     = w_legal & (op[MDU_MULH] | op[MDU_DIV] | op[MDU_REM]) & src2[WIDTH-1];
    assign w_mag1   = w_s1 ? -src1 : src1;
    assign w_mag2   = w_s2 ? -src2 : src2;
    assign w_in_mul = |op[MDU_MULHU:MDU_MUL];
    assign w_div0   = w_legal & (|op[MDU_REMU:MDU_DIV]) & (src2 == '0);
    assign w_ovf    = w_legal & (op[MDU_DIV] | op[MDU_REM]) & (src1 == OVF_QUOT) & (&src2);

    // Multiply: multiplier in acc low half, shifted out LSB-first.
    assign w_is_mul = |r_op[MDU_MULHU:MDU_MUL];
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem  (r_acc[2*WIDTH-1:WIDTH]),
        .i_quot (r_acc[WIDTH-1:0]),
        .i_div  (r_mcand),
        .o_rem  (w_drem),
        .o_quot (w_dquot)
    );

    assign w_acc_nxt = w_is_mul ? {w_sum, r_acc[WIDTH-1:1]} : {w_drem, w_dquot};

    assign w_prod    = r_neg  ? -r_acc : r_acc;
    assign w_quot    = r_neg  ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = r_negr ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_special = special_res(r_op[MDU_REM] | r_op[MDU_REMU], r_div0, r_src1);

    // Illegal requests latch r_op=0, which falls through to a zero result.
    always_comb begin
        w_fix = '0;
        if (r_op[MDU_MUL]) begin
            w_fix = w_prod[WIDTH-1:0];
        end else if (|r_op[MDU_MULHU:MDU_MULH]) begin
            w_fix = w_prod[2*WIDTH-1:WIDTH];
        end else if (|r_op[MDU_REMU:MDU_DIV]) begin
            if (r_div0 | r_ovf) begin
                w_fix = w_special;
            end else if (r_op[MDU_DIV] | r_op[MDU_DIVU]) begin
                w_fix = w_quot;
            end else begin
                w_fix = w_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_src1  <= '0;
            r_res   <= '0;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_negr  <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= w_legal ? op : 8'd0;
                        r_neg   <= w_s1 ^ w_s2;
                        r_negr  <= w_s1;
                        r_div0  <= w_div0;
                        r_ovf   <= w_ovf;
                        r_src1  <= src1;
                        r_acc   <= {{WIDTH{1'b0}}, (w_in_mul ? w_mag2 : w_mag1)};
                        r_mcand <= w_in_mul ? w_mag1 : w_mag2;
                        r_state <= BUSY;
`ifdef MDU_DIV_FAST_EN
                        // Terminal count: the fix-up forces the special result next cycle.
                        r_cnt   <= (w_div0 | w_ovf) ? CNT_W'(WIDTH) : '0;
`else
                        r_cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        r_res   <= w_fix;
                        r_state <= DONE;
                    end else begin
                        r_acc   <= w_acc_nxt;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign res       = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Brief    : Directed self-checking bench for mdu.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu;

`ifdef MDU_DIV_FAST_EN
    localparam int DIV_LAT = 1;
`else
    localparam int DIV_LAT = 33;
`endif
    localparam int MUL_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [7:0]  op;
    logic [31:0] src1, src2, res;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, optionally stall the consumer, then release.
    task automatic run_op(input string tag, input logic [7:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 100);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, res, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_res"}, res, exp);
            check({tag, "_hold_state"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 8'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {29'd0, in_ready, out_valid, (res == 32'd0)}, 32'b101);
        check("reset_res", res, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("mul",    8'h01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, MUL_LAT, 0);
        run_op("mulh",   8'h02, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, 0);
        run_op("mulhu",  8'h08, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, MUL_LAT, 0);
        run_op("div",    8'h10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, MUL_LAT, 0);
        run_op("rem",    8'h40, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, 0);
        run_op("divu",   8'h20, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, MUL_LAT, 0);
        run_op("divu0",  8'h20, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, DIV_LAT, 0);
        run_op("remu0",  8'h80, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, DIV_LAT, 0);
        run_op("div0s",  8'h10, 32'h8765_4321, 32'h0000_0000, 32'hFFFF_FFFF, DIV_LAT, 0);
        run_op("rem0s",  8'h40, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321, DIV_LAT, 0);
        run_op("divovf", 8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT, 0);
        run_op("removf", 8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT, 0);
        run_op("illegal2", 8'h03, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, MUL_LAT, 0);
        run_op("illegal0", 8'h00, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, MUL_LAT, 0);
        run_op("hold",   8'h01, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, MUL_LAT, 5);

        // Flush a divide ten cycles after acceptance.
        @(negedge clk);
        op = 8'h10; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_state", {30'd0, out_valid, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);
        run_op("mulhsu", 8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);

        // Reset mid-operation drops everything back to reset values.
        @(negedge clk);
        op = 8'h01; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midreset_state", {30'd0, out_valid, in_ready}, 32'd1);
        check("midreset_res", res, 32'd0);
        run_op("after_reset", 8'h01, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, MUL_LAT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
